// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control unit: state codes, instruction
// classes, opcode/funct values and datapath select encodings.
package mc_pkg;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_REX    = 4'd7;
    localparam logic [3:0] S_RWB    = 4'd8;
    localparam logic [3:0] S_IEX    = 4'd9;
    localparam logic [3:0] S_IWB    = 4'd10;
    localparam logic [3:0] S_BR     = 4'd11;
    localparam logic [3:0] S_JMP    = 4'd12;

    typedef enum logic [2:0] {
        CLS_LS  = 3'd0,
        CLS_RT  = 3'd1,
        CLS_IT  = 3'd2,
        CLS_BR  = 3'd3,
        CLS_JMP = 3'd4,
        CLS_ILL = 3'd5
    } iclass_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    localparam logic [1:0] ALU_ADD = 2'b10;
    localparam logic [1:0] ALU_SUB = 2'b11;
    localparam logic [1:0] ALU_OR  = 2'b01;

    localparam logic [1:0] EXT_SIGN  = 2'b00;
    localparam logic [1:0] EXT_ZERO  = 2'b01;
    localparam logic [1:0] EXT_UPPER = 2'b10;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B   = 2'b00;
    localparam logic [1:0] SRCB_4   = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;
    localparam logic [1:0] SRCB_BR  = 2'b11;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct from the IR to the
// class that selects the DECODE successor state.
module mc_decode
    import mc_pkg::*;
#(
    parameter int OPC_W = 6
) (
    input  logic [OPC_W-1:0] opcode,
    input  logic [OPC_W-1:0] funct,
    output logic [2:0]       iclass
);

    always_comb begin
        iclass = CLS_ILL;
        case (opcode)
            OP_LW, OP_SW:   iclass = CLS_LS;
            OP_ORI, OP_LUI: iclass = CLS_IT;
            OP_BEQ:         iclass = CLS_BR;
            OP_J:           iclass = CLS_JMP;
            OP_RTYPE: begin
                if (funct == FN_ADDU || funct == FN_SUBU)
                    iclass = CLS_RT;
            end
            default:        iclass = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle control FSM for the MIPS-subset core: instruction phases,
// datapath enables/selects and memory handshake via mem_ready.
//
//   state  | meaning
//   IDLE   | post-reset, all outputs low
//   FETCH  | read instruction at PC, PC+4 into PC when memory answers
//   DECODE | classify instruction, branch target into ALUOut
//   MEMADR | base + sign-extended offset for lw/sw
//   MEMRD  | load data read, waits on mem_ready
//   MEMWB  | MDR into rt
//   MEMWR  | store write, waits on mem_ready
//   REX    | R-type ALU operation
//   RWB    | ALUOut into rd
//   IEX    | ori/lui ALU operation
//   IWB    | ALUOut into rt
//   BR     | beq compare, PC write qualified by zero in datapath
//   JMP    | jump target into PC
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int OPC_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [OPC_W-1:0] opcode,
    input  logic [OPC_W-1:0] funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             memto_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       ext_op,
    output logic             illegal
);

    logic [3:0] state, state_nxt;
    logic [2:0] iclass;
    logic       is_lw, is_sub, is_lui;

    // zero only gates the PC write inside the datapath, never the sequencing
    logic unused_zero;
    assign unused_zero = zero;

    mc_decode #(.OPC_W(OPC_W)) u_decode (
        .opcode (opcode),
        .funct  (funct),
        .iclass (iclass)
    );

    assign is_lw  = (opcode == OP_LW);
    assign is_sub = (funct == FN_SUBU);
    assign is_lui = (opcode == OP_LUI);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   state_nxt = S_FETCH;
            S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (iclass)
                    CLS_LS:  state_nxt = S_MEMADR;
                    CLS_RT:  state_nxt = S_REX;
                    CLS_IT:  state_nxt = S_IEX;
                    CLS_BR:  state_nxt = S_BR;
                    CLS_JMP: state_nxt = S_JMP;
                    default: state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR: state_nxt = is_lw ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_nxt = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_nxt = S_FETCH;
            S_REX:    state_nxt = S_RWB;
            S_IEX:    state_nxt = S_IWB;
            S_MEMWB, S_RWB, S_IWB, S_BR, S_JMP: state_nxt = S_FETCH;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // IR is stable from DECODE onward, so opcode/funct-derived selects act as Moore outputs
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PCS_ALU;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        memto_reg     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = 2'b00;
        ext_op        = EXT_SIGN;
        illegal       = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_4;
                alu_op    = ALU_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = SRCB_BR;
                alu_op    = ALU_ADD;
                illegal   = (iclass == CLS_ILL);
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write = 1'b1;
                memto_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_REX: begin
                alu_src_a = 1'b1;
                alu_op    = is_sub ? ALU_SUB : ALU_ADD;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                alu_op    = is_sub ? ALU_SUB : ALU_ADD;
            end
            S_IEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_OR;
                ext_op    = is_lui ? EXT_UPPER : EXT_ZERO;
            end
            S_IWB: begin
                reg_write = 1'b1;
                alu_op    = ALU_OR;
                ext_op    = is_lui ? EXT_UPPER : EXT_ZERO;
            end
            S_BR: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCS_ALUOUT;
            end
            S_JMP: begin
                pc_write  = 1'b1;
                pc_source = PCS_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-cycle expected control vectors are queued per
// instruction and compared against the DUT one clock at a time.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       reg_write, reg_dst, memto_reg, alu_src_a, illegal;
    logic [1:0] pc_source, alu_src_b, alu_op, ext_op;

    always #5 clk = ~clk;

    mc_ctrl #(.OPC_W(6)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .memto_reg(memto_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .ext_op(ext_op), .illegal(illegal)
    );

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       memto_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] ext_op;
        logic       illegal;
    } out_t;

    typedef struct {
        logic  mr;
        out_t  exp;
        string tag;
    } item_t;

    out_t  obs;
    item_t sb[$];
    int    errors = 0;
    int    checks = 0;

    assign obs = {pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
                  ir_write, reg_write, reg_dst, memto_reg, alu_src_a, alu_src_b,
                  alu_op, ext_op, illegal};

    function automatic out_t e_fetch(input logic mr);
        out_t o = '0;
        o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.alu_op = 2'b10;
        o.ir_write = mr;   o.pc_write = mr;
        return o;
    endfunction

    function automatic out_t e_decode(input logic ill);
        out_t o = '0;
        o.alu_src_b = 2'b11; o.alu_op = 2'b10; o.illegal = ill;
        return o;
    endfunction

    function automatic out_t e_memadr();
        out_t o = '0;
        o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_op = 2'b10;
        return o;
    endfunction

    function automatic out_t e_memrd();
        out_t o = '0;
        o.mem_read = 1'b1; o.iord = 1'b1;
        return o;
    endfunction

    function automatic out_t e_memwb();
        out_t o = '0;
        o.reg_write = 1'b1; o.memto_reg = 1'b1;
        return o;
    endfunction

    function automatic out_t e_memwr();
        out_t o = '0;
        o.mem_write = 1'b1; o.iord = 1'b1;
        return o;
    endfunction

    function automatic out_t e_rex(input logic sub);
        out_t o = '0;
        o.alu_src_a = 1'b1; o.alu_op = sub ? 2'b11 : 2'b10;
        return o;
    endfunction

    function automatic out_t e_rwb(input logic sub);
        out_t o = '0;
        o.reg_write = 1'b1; o.reg_dst = 1'b1; o.alu_op = sub ? 2'b11 : 2'b10;
        return o;
    endfunction

    function automatic out_t e_iex(input logic lui);
        out_t o = '0;
        o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_op = 2'b01;
        o.ext_op = lui ? 2'b10 : 2'b01;
        return o;
    endfunction

    function automatic out_t e_iwb(input logic lui);
        out_t o = '0;
        o.reg_write = 1'b1; o.alu_op = 2'b01; o.ext_op = lui ? 2'b10 : 2'b01;
        return o;
    endfunction

    function automatic out_t e_br();
        out_t o = '0;
        o.alu_src_a = 1'b1; o.alu_op = 2'b11; o.pc_write_cond = 1'b1; o.pc_source = 2'b01;
        return o;
    endfunction

    function automatic out_t e_jmp();
        out_t o = '0;
        o.pc_write = 1'b1; o.pc_source = 2'b10;
        return o;
    endfunction

    task automatic push(input logic mr, input out_t e, input string tag);
        item_t it;
        it.mr = mr; it.exp = e; it.tag = tag;
        sb.push_back(it);
    endtask

    // mem_ready outside FETCH/MEMRD/MEMWR must be ignored, so drive it randomly there
    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic drain();
        item_t it;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            mem_ready = it.mr;
            @(negedge clk);
            checks++;
            if (obs !== it.exp) begin
                errors++;
                $display("FAIL %s: got %b expected %b", it.tag, obs, it.exp);
            end
            checks++;
            if (((obs.mem_read & obs.mem_write) | (obs.reg_write & obs.pc_write)) !== 1'b0) begin
                errors++;
                $display("FAIL %s exclusive strobes: got %b expected no overlap", it.tag, obs);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                            input int mw, input logic z, input string nm);
        opcode = op; funct = fn; zero = z;
        for (int i = 0; i < fw; i++) push(1'b0, e_fetch(1'b0), {nm, " fetch-wait"});
        push(1'b1, e_fetch(1'b1), {nm, " fetch"});
        case (op)
            6'b100011: begin
                push(rnd(), e_decode(1'b0), {nm, " decode"});
                push(rnd(), e_memadr(), {nm, " memadr"});
                for (int i = 0; i < mw; i++) push(1'b0, e_memrd(), {nm, " memrd-wait"});
                push(1'b1, e_memrd(), {nm, " memrd"});
                push(rnd(), e_memwb(), {nm, " memwb"});
            end
            6'b101011: begin
                push(rnd(), e_decode(1'b0), {nm, " decode"});
                push(rnd(), e_memadr(), {nm, " memadr"});
                for (int i = 0; i < mw; i++) push(1'b0, e_memwr(), {nm, " memwr-wait"});
                push(1'b1, e_memwr(), {nm, " memwr"});
            end
            6'b000000: begin
                if (fn == 6'b100001 || fn == 6'b100011) begin
                    push(rnd(), e_decode(1'b0), {nm, " decode"});
                    push(rnd(), e_rex(fn == 6'b100011), {nm, " rex"});
                    push(rnd(), e_rwb(fn == 6'b100011), {nm, " rwb"});
                end else begin
                    push(rnd(), e_decode(1'b1), {nm, " decode-illegal"});
                end
            end
            6'b001101, 6'b001111: begin
                push(rnd(), e_decode(1'b0), {nm, " decode"});
                push(rnd(), e_iex(op == 6'b001111), {nm, " iex"});
                push(rnd(), e_iwb(op == 6'b001111), {nm, " iwb"});
            end
            6'b000100: begin
                push(rnd(), e_decode(1'b0), {nm, " decode"});
                push(rnd(), e_br(), {nm, " br"});
            end
            6'b000010: begin
                push(rnd(), e_decode(1'b0), {nm, " decode"});
                push(rnd(), e_jmp(), {nm, " jmp"});
            end
            default: push(rnd(), e_decode(1'b1), {nm, " decode-illegal"});
        endcase
        drain();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; mem_ready = 1'b1; opcode = '0; funct = '0; zero = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (obs !== '0) begin
                errors++;
                $display("FAIL reset hold: got %b expected all zero", obs);
            end
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        push(1'b1, '0, "idle after reset");
        drain();
    endtask

    task automatic test_rtype();
        do_instr(6'b000000, 6'b100001, 0, 0, 1'b0, "addu");
        do_instr(6'b000000, 6'b100011, 0, 0, 1'b0, "subu");
        do_instr(6'b000000, 6'b000000, 0, 0, 1'b0, "bad-funct");
    endtask

    task automatic test_lw_wait();
        do_instr(6'b100011, 6'b000000, 0, 2, 1'b0, "lw");
    endtask

    task automatic test_branch();
        do_instr(6'b000100, 6'b000000, 0, 0, 1'b1, "beq-z1");
        do_instr(6'b000100, 6'b000000, 0, 0, 1'b0, "beq-z0");
    endtask

    task automatic test_imm();
        do_instr(6'b001111, 6'b000000, 0, 0, 1'b0, "lui");
        do_instr(6'b001101, 6'b000000, 0, 0, 1'b0, "ori");
        do_instr(6'b111111, 6'b000000, 0, 0, 1'b0, "illegal-op");
    endtask

    task automatic test_back_to_back();
        do_instr(6'b101011, 6'b000000, 1, 1, 1'b0, "sw");
        do_instr(6'b000010, 6'b000000, 0, 0, 1'b0, "j");
        do_instr(6'b000000, 6'b100001, 3, 0, 1'b0, "addu-slowfetch");
        do_instr(6'b100011, 6'b000000, 0, 0, 1'b0, "lw-fast");
    endtask

    task automatic test_reset_midop();
        opcode = 6'b101011; funct = '0;
        push(1'b1, e_fetch(1'b1), "sw-abort fetch");
        push(rnd(), e_decode(1'b0), "sw-abort decode");
        push(rnd(), e_memadr(), "sw-abort memadr");
        push(1'b0, e_memwr(), "sw-abort memwr-wait");
        drain();
        mem_ready = 1'b0;
        #1;
        checks++;
        if (mem_write !== 1'b1) begin
            errors++;
            $display("FAIL sw-abort pre-reset mem_write: got %b expected 1", mem_write);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL sw-abort async reset: got %b expected all zero", obs);
        end
        @(posedge clk);
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL sw-abort reset held: got %b expected all zero", obs);
        end
        reset_n = 1'b1;
        push(1'b0, '0, "sw-abort idle");
        drain();
        do_instr(6'b000000, 6'b100011, 0, 0, 1'b0, "subu-after-abort");
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_branch();
        test_imm();
        test_back_to_back();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
